// File: rtl/note_player_ctrl.sv
// Note-player control: accepts notes from the song reader, places them in one of
// three voice slots, counts their duration in beats and returns done handshakes.
module note_player_ctrl #(
   parameter int NOTE_WIDTH     = 6,
   parameter int DURATION_WIDTH = 6,
   parameter int NUM_VOICES     = 3
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               play,
   input  logic                               beat,
   input  logic                               new_note,
   input  logic [NOTE_WIDTH-1:0]              note,
   input  logic [DURATION_WIDTH-1:0]          duration,
   input  logic                               activate,
   output logic                               note_done,
   output logic                               activate_done,
   output logic [NUM_VOICES*NOTE_WIDTH-1:0]   voice_notes,
   output logic [NUM_VOICES-1:0]              voice_active,
   output logic                               busy
);

   localparam int IDX_W = 2;
   localparam logic [DURATION_WIDTH-1:0] ZERO_DUR = {DURATION_WIDTH{1'b0}};
   localparam logic [DURATION_WIDTH-1:0] ONE_DUR  = DURATION_WIDTH'(1);
   localparam logic [DURATION_WIDTH-1:0] MAX_DUR  = {DURATION_WIDTH{1'b1}};
   localparam logic [NOTE_WIDTH-1:0]     ZERO_NOTE = {NOTE_WIDTH{1'b0}};

   logic [NUM_VOICES-1:0]     active_r;
   logic [NUM_VOICES-1:0]     active_s;
   logic [NOTE_WIDTH-1:0]     note_r [NUM_VOICES];
   logic [NOTE_WIDTH-1:0]     note_s [NUM_VOICES];
   logic [DURATION_WIDTH-1:0] rem_r  [NUM_VOICES];
   logic [DURATION_WIDTH-1:0] rem_s  [NUM_VOICES];
   logic                      lead_valid_r;
   logic                      lead_valid_s;
   logic [IDX_W-1:0]          lead_idx_r;
   logic [IDX_W-1:0]          lead_idx_s;
   logic                      note_done_r;
   logic                      note_done_s;
   logic                      activate_done_r;
   logic                      activate_done_s;
   logic [IDX_W-1:0]          slot_s;
   logic                      found_s;
   logic [DURATION_WIDTH-1:0] best_rem_s;
   logic                      load_s;

   // Pick the target slot from pre-edge state: lead reuse, free slot, or shortest remaining
   always_comb begin
      slot_s     = {IDX_W{1'b0}};
      found_s    = 1'b0;
      best_rem_s = MAX_DUR;
      if (!activate && lead_valid_r) begin
         slot_s = lead_idx_r;
      end else begin
         // Descending scans let the lowest index win both searches
         for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!active_r[i]) begin
               slot_s  = IDX_W'(i);
               found_s = 1'b1;
            end else begin
               slot_s = slot_s;
            end
         end
         if (!found_s) begin
            for (int i = NUM_VOICES - 1; i >= 0; i--) begin
               if (!(activate && lead_valid_r && lead_idx_r == IDX_W'(i)) &&
                   rem_r[i] <= best_rem_s) begin
                  slot_s     = IDX_W'(i);
                  best_rem_s = rem_r[i];
               end else begin
                  best_rem_s = best_rem_s;
               end
            end
         end else begin
            best_rem_s = MAX_DUR;
         end
      end
   end

   // Next-state: load, beat countdown, expiry and handshake pulses while playing
   always_comb begin
      load_s          = new_note && (duration != ZERO_DUR);
      active_s        = active_r;
      note_s          = note_r;
      rem_s           = rem_r;
      lead_valid_s    = lead_valid_r;
      lead_idx_s      = lead_idx_r;
      note_done_s     = 1'b0;
      activate_done_s = new_note && activate;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (load_s && slot_s == IDX_W'(i)) begin
            active_s[i] = 1'b1;
            note_s[i]   = note;
            rem_s[i]    = duration;
         end else if (beat && active_r[i] && rem_r[i] != ZERO_DUR) begin
            rem_s[i] = rem_r[i] - ONE_DUR;
            if (rem_r[i] == ONE_DUR) begin
               active_s[i] = 1'b0;
               if (lead_valid_r && lead_idx_r == IDX_W'(i)) begin
                  lead_valid_s = 1'b0;
                  note_done_s  = 1'b1;
               end else begin
                  note_done_s = note_done_s;
               end
            end else begin
               active_s[i] = active_r[i];
            end
         end else begin
            rem_s[i] = rem_r[i];
         end
      end
      if (new_note && !activate) begin
         if (load_s) begin
            lead_valid_s = 1'b1;
            lead_idx_s   = slot_s;
         end else begin
            // Zero-length lead completes at once without occupying a slot
            note_done_s = 1'b1;
         end
      end else begin
         lead_idx_s = lead_idx_s;
      end
   end

   // State registers; a paused edge drops every voice and any pending pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         active_r        <= {NUM_VOICES{1'b0}};
         lead_valid_r    <= 1'b0;
         lead_idx_r      <= {IDX_W{1'b0}};
         note_done_r     <= 1'b0;
         activate_done_r <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_r[i] <= ZERO_NOTE;
            rem_r[i]  <= ZERO_DUR;
         end
      end else if (!play) begin
         active_r        <= {NUM_VOICES{1'b0}};
         lead_valid_r    <= 1'b0;
         note_done_r     <= 1'b0;
         activate_done_r <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            rem_r[i] <= ZERO_DUR;
         end
      end else begin
         active_r        <= active_s;
         note_r          <= note_s;
         rem_r           <= rem_s;
         lead_valid_r    <= lead_valid_s;
         lead_idx_r      <= lead_idx_s;
         note_done_r     <= note_done_s;
         activate_done_r <= activate_done_s;
      end
   end

   // Silent voices present note code 0 to the synthesis path
   always_comb begin
      voice_notes = {(NUM_VOICES*NOTE_WIDTH){1'b0}};
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_notes[i*NOTE_WIDTH +: NOTE_WIDTH] = active_r[i] ? note_r[i] : ZERO_NOTE;
      end
   end

   assign voice_active  = active_r;
   assign busy          = |active_r;
   assign note_done     = note_done_r;
   assign activate_done = activate_done_r;

endmodule

// File: tb/tb_note_player_ctrl.sv
// Bench for note_player_ctrl: directed scenarios plus random traffic, all checked
// against a cycle-level voice-slot model kept here.
module tb_note_player_ctrl;

   logic        clk = 1'b0;
   logic        reset, play, beat, new_note, activate;
   logic [5:0]  note, duration;
   logic        note_done, activate_done, busy;
   logic [17:0] voice_notes;
   logic [2:0]  voice_active;

   int n_vec = 0;
   int n_err = 0;

   // Model state
   int m_act[3], m_note[3], m_rem[3];
   int m_lead_v, m_lead, m_nd, m_ad;

   note_player_ctrl dut (
      .clk(clk), .reset(reset), .play(play), .beat(beat), .new_note(new_note),
      .note(note), .duration(duration), .activate(activate),
      .note_done(note_done), .activate_done(activate_done),
      .voice_notes(voice_notes), .voice_active(voice_active), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input int ac);
      int best;
      if (ac == 0 && m_lead_v != 0) return m_lead;
      for (int i = 0; i < 3; i++) if (m_act[i] == 0) return i;
      best = -1;
      for (int i = 0; i < 3; i++) begin
         if (ac != 0 && m_lead_v != 0 && m_lead == i) continue;
         if (best < 0 || m_rem[i] < m_rem[best]) best = i;
      end
      return best;
   endfunction

   task automatic model_edge(input int rst, input int pl, input int bt, input int nn,
                             input int nt, input int du, input int ac);
      int slot;
      int nd;
      if (rst != 0) begin
         for (int i = 0; i < 3; i++) begin m_act[i] = 0; m_note[i] = 0; m_rem[i] = 0; end
         m_lead_v = 0; m_lead = 0; m_nd = 0; m_ad = 0;
      end else if (pl == 0) begin
         for (int i = 0; i < 3; i++) m_act[i] = 0;
         m_lead_v = 0; m_nd = 0; m_ad = 0;
      end else begin
         nd = 0;
         slot = (nn != 0) ? pick(ac) : -1;
         for (int i = 0; i < 3; i++) begin
            if (bt != 0 && m_act[i] != 0 && !(nn != 0 && du > 0 && i == slot)) begin
               m_rem[i] = m_rem[i] - 1;
               if (m_rem[i] == 0) begin
                  m_act[i] = 0;
                  if (m_lead_v != 0 && m_lead == i) begin m_lead_v = 0; nd = 1; end
               end
            end
         end
         if (nn != 0 && du > 0) begin
            m_act[slot] = 1; m_note[slot] = nt; m_rem[slot] = du;
            if (ac == 0) begin m_lead_v = 1; m_lead = slot; end
         end
         if (nn != 0 && du == 0 && ac == 0) nd = 1;
         m_nd = nd;
         m_ad = (nn != 0 && ac != 0) ? 1 : 0;
      end
   endtask

   task automatic compare_all();
      int ev, en;
      ev = 0; en = 0;
      for (int i = 0; i < 3; i++) begin
         if (m_act[i] != 0) begin
            ev = ev | (1 << i);
            en = en | (m_note[i] << (6 * i));
         end
      end
      chk("voice_active", int'(voice_active), ev);
      chk("voice_notes", int'(voice_notes), en);
      chk("busy", int'(busy), (ev != 0) ? 1 : 0);
      chk("note_done", int'(note_done), m_nd);
      chk("activate_done", int'(activate_done), m_ad);
   endtask

   // Called at a negedge: drive one edge's inputs, advance model, check after the edge
   task automatic step(input int rst, input int pl, input int bt, input int nn,
                       input int nt, input int du, input int ac);
      reset = rst[0]; play = pl[0]; beat = bt[0]; new_note = nn[0];
      note = 6'(nt); duration = 6'(du); activate = ac[0];
      model_edge(rst, pl, bt, nn, nt, du, ac);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0, 0);
   endtask

   task automatic beat_then_gap();
      step(0, 1, 1, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; play = 1'b0; beat = 1'b0; new_note = 1'b0;
      note = 6'd0; duration = 6'd0; activate = 1'b0;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("reset_active", int'(voice_active), 0);

      // Lead note of 3 beats, beats 4 cycles apart
      step(0, 1, 0, 1, 20, 3, 0);
      chk("lead_active", int'(voice_active), 1);
      chk("lead_note", int'(voice_notes[5:0]), 20);
      beat_then_gap(); idle(3);
      beat_then_gap(); idle(3);
      beat_then_gap();
      chk("lead_done", int'(note_done), 1);
      chk("lead_gone", int'(voice_active), 0);
      idle(1);
      chk("lead_done_once", int'(note_done), 0);

      // Chord then lead
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 10, 5, 1);
      chk("chord_ack", int'(activate_done), 1);
      step(0, 1, 0, 1, 14, 2, 0);
      chk("chord_lead_active", int'(voice_active), 3);
      beat_then_gap(); idle(1); beat_then_gap();
      chk("chord_lead_done", int'(note_done), 1);
      chk("chord_still", int'(voice_active), 1);

      // Full slots: chord replaces shortest non-lead
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 11, 4, 1);
      step(0, 1, 0, 1, 12, 2, 1);
      step(0, 1, 0, 1, 13, 6, 0);
      step(0, 1, 0, 1, 33, 1, 1);
      chk("full_slot1", int'(voice_notes[11:6]), 33);
      chk("full_lead_kept", int'(voice_notes[17:12]), 13);
      chk("full_ack", int'(activate_done), 1);

      // Zero-duration notes
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 9, 0, 0);
      chk("dur0_lead_done", int'(note_done), 1);
      chk("dur0_idle", int'(voice_active), 0);
      step(0, 1, 0, 1, 9, 0, 1);
      chk("dur0_chord_ack", int'(activate_done), 1);

      // Pause drops state; notes while paused are ignored; re-issue counts in full
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 30, 5, 0);
      beat_then_gap(); beat_then_gap();
      step(0, 0, 0, 0, 0, 0, 0);
      chk("pause_clear", int'(voice_active), 0);
      step(0, 0, 0, 1, 31, 4, 0);
      chk("pause_ignore", int'(voice_active), 0);
      step(0, 1, 0, 1, 30, 5, 0);
      for (int k = 0; k < 5; k++) beat_then_gap();
      chk("resume_done", int'(note_done), 1);

      // Beat colliding with load, then reset mid-note
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 7, 2, 1);
      step(0, 1, 1, 1, 8, 4, 0);
      chk("collide_new", int'(voice_notes[11:6]), 8);
      step(0, 1, 1, 0, 0, 0, 0);
      chk("collide_expired", int'(voice_active), 2);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("midreset", int'(voice_active), 0);

      // Random traffic
      for (int k = 0; k < 4000; k++) begin
         step(($urandom_range(0, 199) == 0) ? 1 : 0,
              ($urandom_range(0, 31) == 0) ? 0 : 1,
              ($urandom_range(0, 3) == 0) ? 1 : 0,
              ($urandom_range(0, 2) == 0) ? 1 : 0,
              int'($urandom_range(0, 63)),
              int'($urandom_range(0, 9)),
              int'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/note_player_ctrl.md
Name: note_player_ctrl

Overview:
- Consumer end of the song-reader note handshake.
- Accepts `new_note` pulses carrying note, duration and activate. Allocates each note to one of 3 voice slots and counts its duration in beats.
- Returns `note_done` when a lead (non-activate) note expires, and `activate_done` immediately for chord (activate) notes.
- Drives the per-voice note codes and active flags consumed by the synthesis/sample path.

Parameters:
- NOTE_WIDTH, 6, width of note code.
- DURATION_WIDTH, 6, width of duration in beats.
- NUM_VOICES, 3, voice slots; fixed at 3, bench covers 3 only.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- play  in  1  1 = playing; 0 = paused.
- beat  in  1  one-cycle tick per beat; duration unit.
- new_note  in  1  one-cycle strobe; note/duration/activate valid this cycle.
- note  in  6  note code; 0 = rest (slot loaded, no sound).
- duration  in  6  length in beats.
- activate  in  1  1 = chord note: do not hold handshake; 0 = lead note.
- note_done  out  1  one-cycle pulse: lead note finished.
- activate_done  out  1  one-cycle pulse: chord note accepted.
- voice_notes  out  18  {v2,v1,v0} note codes, 6 bits each.
- voice_active  out  3  per-voice active flag, bit i = voice i.
- busy  out  1  OR of voice_active.

Behaviour:
- Reset: all voice counters, notes, active flags and lead pointer = 0. `note_done`, `activate_done`, `busy` = 0. Reset mid-note drops everything with no done pulse.
- Per-voice state: `active`, `note[5:0]`, `remaining[5:0]`. Plus `lead_valid` and `lead_idx[1:0]`.
- Accept: `new_note` sampled at a clk edge while `play`=1. `new_note` while `play`=0 is ignored, no pulses.
- Slot choice, evaluated on pre-edge state:
  - Activate=0 with `lead_valid`=1: the current lead slot is reused (old lead overwritten, no `note_done` for it).
  - Otherwise: lowest-index inactive slot.
  - If all active: the slot with the smallest `remaining`; ties go to the lowest index.
  - Activate=1 never overwrites the lead slot while `lead_valid`. If the only candidates are lead, the smallest non-lead slot is taken.
- Load: `active`=1, `note`=note, `remaining`=duration. The loaded slot is not decremented on that edge even if `beat`=1.
- Activate=0 load: `lead_valid`=1, `lead_idx`=slot.
- Activate=1 load: `activate_done`=1 in the cycle after the accepting edge (latency 1), for one cycle.
- Duration 0:
  - Slot is not loaded.
  - Activate=0: `note_done` pulses in the cycle after accept.
  - Activate=1: `activate_done` pulses in the cycle after accept.
- Countdown: on an edge with `beat`=1 and `play`=1, every active slot not being loaded decrements `remaining`.
- Expiry:
  - A slot reaching 0 clears `active` on that same edge.
  - If it is the lead slot, `lead_valid` clears and `note_done` = 1 for the following cycle only.
- Pause: an edge with `play`=0 clears all `active`, `lead_valid` and the pending pulses. The reader re-issues the current note on resume, so no state is held. No `note_done` is generated while paused.
- `voice_notes` slot i = stored note if active, else 0.
- `busy` = |voice_active (registered state, no input combinational path).
- `note_done` and `activate_done` are registered and never both asserted for the same accept. Both may be high in one cycle only if a lead expiry and a chord accept coincide.
- Arithmetic: `remaining` is unsigned and never wraps; decrement occurs only when `remaining` ≥ 1.
- All outputs are registered or decoded from registers; no combinational path from inputs to outputs.

Test Plan:
- Lead note: reset, play=1, new_note (note=20, dur=3, act=0), then 3 beats spaced 4 cycles apart.
  - voice_active=001 and voice_notes[5:0]=20 the cycle after accept.
  - note_done pulses exactly one cycle, the cycle after the 3rd beat edge; voice_active=000 then.
- Chord then lead:
  - new_note (note=10, dur=5, act=1) → activate_done pulse next cycle; slot 0 active.
  - new_note (note=14, dur=2, act=0) → slot 1 active, voice_active=011.
  - After 2 beats: note_done pulses; slot 0 remaining=3, still active.
- Full slots: fill 3 voices (remaining 4, 2, 6; slot 2 lead), then chord new_note dur=1 → replaces slot 1. Slot 2 untouched; activate_done pulses.
- Duration 0: new_note act=0 dur=0 → note_done next cycle, voice_active stays 000. Same with act=1 → activate_done next cycle.
- Pause/ignore: lead note dur=5, two beats, drop play for 1 cycle → voice_active=000, no note_done. new_note while play=0 → ignored. Re-issue on play=1 → full 5-beat count.
- Beat collision: beat and new_note on the same edge with slot 0 active (remaining=2) → slot 0 remaining=1; new slot holds the full duration. Synchronous reset mid-note → all outputs 0 next cycle, no pulses.
